tone_sequencer: RTL and testbench
=================================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter SLOW_DIV, default 100_000_000, giving the step period in clocks when speed=0 (1 s at 100 MHz).
REQ-002 SHALL have parameter FAST_DIV, default 50_000_000, giving the step period in clocks when speed=1 (0.5 s).
REQ-003 SHALL have parameter NUM_NOTES, default 29, giving the number of scale notes; one-hot width = NUM_NOTES.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that restarts the sequence.
REQ-007 SHALL have ports up_req and down_req, input, 1 bit each: level direction requests.
REQ-008 SHALL have port speed_tgl, input, 1 bit: one-cycle pulse that toggles speed.
REQ-009 SHALL have port pause_tgl, input, 1 bit: one-cycle pulse that toggles pause.
REQ-010 SHALL have port bounce, input, 1 bit: 1 = reverse at the ends, 0 = stop at the ends.
REQ-011 SHALL have port tone, output, NUM_NOTES bits: one-hot note, bit i = note index i.
REQ-012 SHALL have port note_idx, output, 5 bits: binary index of the current note.
REQ-013 SHALL have port audio_en, output, 1 bit: enable for the PWM generator.
REQ-014 SHALL have ports step_pulse, at_top and at_bottom, output, 1 bit each.
REQ-015 SHALL have ports speed and dir, output, 1 bit each: current speed and direction (1 = up).

Function
REQ-016 SHALL implement states IDLE, RUN, HOLD and END.
REQ-017 audio_en SHALL be 1 in RUN and END, and 0 in IDLE and HOLD.
REQ-018 start SHALL, from any state, set state=RUN, note_idx=0, dir=1, speed=1 and step counter=0, registered on the next clock edge.
REQ-019 start SHALL take priority over every other input in the same cycle.
REQ-020 In RUN the step counter SHALL count 0 to P-1, where P = speed ? FAST_DIV : SLOW_DIV.
REQ-021 When the counter equals P-1 the block SHALL wrap it to 0, pulse step_pulse high for exactly one cycle, and update note_idx on that same edge.
REQ-022 A step SHALL change note_idx by +1 if dir=1 and by -1 if dir=0.
REQ-023 The first step after start SHALL occur P clocks after start is registered.
REQ-024 Boundary rule, bounce=1: a step at idx NUM_NOTES-1 with dir=1 SHALL flip dir to 0 and set idx=NUM_NOTES-2 (mirror rule at idx 0 with dir=0: flip dir to 1, set idx=1).
REQ-025 Boundary rule, bounce=0: such a step SHALL leave idx unchanged, go to END and freeze the counter; step_pulse still asserts.
REQ-026 In END, a direction request pointing away from the boundary SHALL set dir, clear the counter and return to RUN.
REQ-027 up_req=1 with down_req=0 SHALL set dir=1; down_req=1 with up_req=0 SHALL set dir=0; both or neither SHALL leave dir unchanged.
REQ-028 A direction change SHALL apply at the next step without clearing the counter.
REQ-029 speed_tgl SHALL invert speed and clear the counter in RUN, HOLD or END, and SHALL be ignored in IDLE.
REQ-030 pause_tgl SHALL toggle between RUN and HOLD, and SHALL be ignored in IDLE and END.
REQ-031 In HOLD the counter SHALL be frozen; on resume, counting SHALL continue from the frozen value.
REQ-032 Simultaneous speed_tgl and pause_tgl SHALL both be applied.
REQ-033 tone SHALL always equal 1 << note_idx and be exactly one-hot.
REQ-034 at_top SHALL equal (note_idx == NUM_NOTES-1); at_bottom SHALL equal (note_idx == 0).
REQ-035 The counter SHALL be ceil(log2(max(SLOW_DIV, FAST_DIV))) bits wide and SHALL never exceed P-1 after a speed change.

Reset
REQ-036 On rst low, outputs SHALL reset to: state=IDLE, note_idx=0, tone=1, dir=1, speed=1, audio_en=0, step_pulse=0, counter=0.
REQ-037 rst asserted mid-RUN SHALL abort immediately, with audio_en=0 asynchronously.
REQ-038 After release the block SHALL stay in IDLE until start.

Structure
REQ-039 A shared package tone_seq_pkg SHALL hold the state enum, NUM_NOTES, the index width and the default SLOW_DIV and FAST_DIV values.
REQ-040 The design SHALL contain one sub-module, step_timer: a period counter with clear, enable and a terminal-count pulse.

Verification (SLOW_DIV=8, FAST_DIV=4, NUM_NOTES=29)
REQ-041 Scenario: start; hold inputs idle -> step_pulse at cycles 4, 8 and 12 after start; note_idx = 1, 2, 3; tone = 0x2, 0x4, 0x8.
REQ-042 Scenario: bounce=0; run up to the top -> note_idx=28, tone bit 28 set, state END, audio_en=1; then down_req -> RUN, next step gives idx 27.
REQ-043 Scenario: bounce=1; run up to the top -> idx sequence 27, 28, 27, 26 with dir=0 after the step at idx 28.
REQ-044 Scenario: speed_tgl at counter=2 -> speed=0 and counter=0; the next step comes 8 cycles later.
REQ-045 Scenario: pause_tgl at counter=1, wait 20 cycles, pause_tgl -> no step and audio_en=0 while paused; after resume, the step comes 3 cycles later.
REQ-046 Scenario: assert rst mid-RUN at idx 5, then start in the same cycle as up_req+down_req and pause_tgl -> reset values seen; after start, idx=0, dir=1, state RUN.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// rtl/tone_seq_pkg.sv - shared states, scale size and default step periods for the tone sequencer
package tone_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    END
  } state_t;

  localparam int NUM_NOTES_DEFAULT = 29;
  localparam int IDX_W             = 5;
  localparam int SLOW_DIV_DEFAULT  = 100_000_000;
  localparam int FAST_DIV_DEFAULT  = 50_000_000;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - step period counter with clear, enable and terminal-count pulse
module step_timer
  import tone_seq_pkg::*;
#(
  parameter int SLOW_DIV = SLOW_DIV_DEFAULT,
  parameter int FAST_DIV = FAST_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic speed,
  output logic tc
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CNT_W   = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  assign last = speed ? FAST_LAST : SLOW_LAST;
  assign tc   = en && (cnt == last);

  // clear wins over enable so a speed change never leaves cnt above the new last value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == last) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - walks a one-hot note scale up/down at a selectable step rate
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int SLOW_DIV  = SLOW_DIV_DEFAULT,
  parameter int FAST_DIV  = FAST_DIV_DEFAULT,
  parameter int NUM_NOTES = NUM_NOTES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 up_req,
  input  logic                 down_req,
  input  logic                 speed_tgl,
  input  logic                 pause_tgl,
  input  logic                 bounce,
  output logic [NUM_NOTES-1:0] tone,
  output logic [IDX_W-1:0]     note_idx,
  output logic                 audio_en,
  output logic                 step_pulse,
  output logic                 at_top,
  output logic                 at_bottom,
  output logic                 speed,
  output logic                 dir
);

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_NOTES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_d;
  logic             dir_d, speed_d;
  logic             up_only, down_only, spd_apply, end_exit;
  logic             cnt_clr, cnt_en, tc;

  assign up_only   = up_req & ~down_req;
  assign down_only = down_req & ~up_req;
  assign at_top    = (note_idx == TOP_IDX);
  assign at_bottom = (note_idx == '0);
  assign spd_apply = speed_tgl && (state_q != IDLE);
  assign end_exit  = (state_q == END) && ((at_top && down_only) || (at_bottom && up_only));
  assign cnt_clr   = start || spd_apply || end_exit;
  // a pause edge freezes the counter on that same edge so resume continues from it
  assign cnt_en    = (state_q == RUN) && !pause_tgl && !cnt_clr;
  assign audio_en  = (state_q == RUN) || (state_q == END);
  assign tone      = NUM_NOTES'(1) << note_idx;

  step_timer #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .speed (speed),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = note_idx;
    dir_d   = dir;
    speed_d = speed;
    if (start) begin
      state_d = RUN;
      idx_d   = '0;
      dir_d   = 1'b1;
      speed_d = 1'b1;
    end else begin
      if ((state_q == RUN || state_q == HOLD) && (up_only || down_only)) dir_d = up_only;
      unique case (state_q)
        RUN: begin
          if (tc) begin
            if (dir_d && at_top) begin
              if (bounce) begin
                dir_d = 1'b0;
                idx_d = TOP_IDX - 1'b1;
              end else begin
                state_d = END;
              end
            end else if (!dir_d && at_bottom) begin
              if (bounce) begin
                dir_d = 1'b1;
                idx_d = IDX_W'(1);
              end else begin
                state_d = END;
              end
            end else begin
              idx_d = dir_d ? note_idx + 1'b1 : note_idx - 1'b1;
            end
          end
          if (pause_tgl) state_d = HOLD;
        end
        HOLD: if (pause_tgl) state_d = RUN;
        END: begin
          if (end_exit) begin
            state_d = RUN;
            dir_d   = up_only;
          end
        end
        default: ;
      endcase
      if (spd_apply) speed_d = ~speed;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      note_idx   <= '0;
      dir        <= 1'b1;
      speed      <= 1'b1;
      step_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx   <= idx_d;
      dir        <= dir_d;
      speed      <= speed_d;
      step_pulse <= tc;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer with a behavioural reference model
module tb_tone_sequencer;

  localparam int SLOW = 8;
  localparam int FAST = 4;
  localparam int NN   = 29;
  localparam int TOP  = NN - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_END = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, up_req = 1'b0, down_req = 1'b0;
  logic speed_tgl = 1'b0, pause_tgl = 1'b0, bounce = 1'b0;
  logic [NN-1:0] tone;
  logic [4:0] note_idx;
  logic audio_en, step_pulse, at_top, at_bottom, speed, dir;

  int checks = 0;
  int errors = 0;

  int m_mode, m_idx, m_cnt;
  bit m_dir, m_speed, m_pulse;

  typedef struct {
    bit start, up, down, spd, pse;
    int hold;
    int idx;
    bit dir, speed, audio, pulse;
  } vec_t;
  vec_t vecs[12];

  tone_sequencer #(
    .SLOW_DIV  (SLOW),
    .FAST_DIV  (FAST),
    .NUM_NOTES (NN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .up_req     (up_req),
    .down_req   (down_req),
    .speed_tgl  (speed_tgl),
    .pause_tgl  (pause_tgl),
    .bounce     (bounce),
    .tone       (tone),
    .note_idx   (note_idx),
    .audio_en   (audio_en),
    .step_pulse (step_pulse),
    .at_top     (at_top),
    .at_bottom  (at_bottom),
    .speed      (speed),
    .dir        (dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_cnt = 0;
    m_dir = 1'b1; m_speed = 1'b1; m_pulse = 1'b0;
  endtask

  // a step moves one note along dir; stepping off either end reflects (bounce) or stops
  task automatic take_step();
    int nxt;
    nxt = m_idx + (m_dir ? 1 : -1);
    if (nxt < 0 || nxt > TOP) begin
      if (bounce) begin
        m_dir = !m_dir;
        m_idx = m_idx + (m_dir ? 1 : -1);
      end else begin
        m_mode = M_END;
      end
    end else begin
      m_idx = nxt;
    end
  endtask

  task automatic model_update();
    bit up_only, dn_only, spd;
    int period;
    if (!rst) begin
      model_reset();
      return;
    end
    m_pulse = 1'b0;
    if (start) begin
      m_mode = M_RUN; m_idx = 0; m_dir = 1'b1; m_speed = 1'b1; m_cnt = 0;
      return;
    end
    up_only = up_req && !down_req;
    dn_only = down_req && !up_req;
    spd     = speed_tgl && (m_mode != M_IDLE);
    period  = m_speed ? FAST : SLOW;
    if (m_mode == M_RUN || m_mode == M_HOLD) begin
      if (up_only) m_dir = 1'b1;
      else if (dn_only) m_dir = 1'b0;
      if (m_mode == M_RUN && !pause_tgl && !spd) begin
        m_cnt++;
        if (m_cnt == period) begin
          m_cnt = 0;
          m_pulse = 1'b1;
          take_step();
        end
      end
      if (pause_tgl) m_mode = (m_mode == M_RUN) ? M_HOLD : M_RUN;
    end else if (m_mode == M_END) begin
      if ((m_idx == TOP && dn_only) || (m_idx == 0 && up_only)) begin
        m_dir = up_only; m_mode = M_RUN; m_cnt = 0;
      end
    end
    if (spd) begin
      m_speed = !m_speed;
      m_cnt = 0;
    end
  endtask

  task automatic compare_all();
    logic [NN-1:0] et;
    et = '0;
    et[m_idx] = 1'b1;
    chk("note_idx", note_idx, m_idx);
    chk("tone", tone, et);
    chk("dir", dir, m_dir);
    chk("speed", speed, m_speed);
    chk("audio_en", audio_en, (m_mode == M_RUN || m_mode == M_END));
    chk("step_pulse", step_pulse, m_pulse);
    chk("at_top", at_top, m_idx == TOP);
    chk("at_bottom", at_bottom, m_idx == 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #2;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 1'b0; up_req = 1'b0; down_req = 1'b0; speed_tgl = 1'b0; pause_tgl = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    idle_inputs();
  endtask

  task automatic cycles_to_step(input string name, input int exp);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!step_pulse && n < 40);
    chk(name, n, exp);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_idx"}, note_idx, 0);
    chk({tag, "_tone"}, tone, 1);
    chk({tag, "_dir"}, dir, 1);
    chk({tag, "_speed"}, speed, 1);
    chk({tag, "_audio"}, audio_en, 0);
    chk({tag, "_pulse"}, step_pulse, 0);
  endtask

  initial begin
    int quiet_bad;
    int idx_seen;
    model_reset();

    vecs[0]  = '{1, 0, 0, 0, 0, 1,  0, 1, 1, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 4,  1, 1, 1, 1, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 4,  2, 1, 1, 1, 1};
    vecs[3]  = '{0, 0, 0, 0, 0, 4,  3, 1, 1, 1, 1};
    vecs[4]  = '{0, 0, 0, 1, 0, 1,  3, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 7,  3, 1, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 1,  4, 1, 0, 1, 1};
    vecs[7]  = '{0, 0, 0, 0, 1, 1,  4, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 20, 4, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 1, 1,  4, 1, 0, 1, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 8,  3, 0, 0, 1, 1};
    vecs[11] = '{0, 1, 1, 0, 0, 8,  2, 0, 0, 1, 1};

    repeat (3) cycle();
    check_reset_values("reset");
    rst = 1'b1;
    repeat (5) cycle();
    chk("idle_audio", audio_en, 0);
    chk("idle_idx", note_idx, 0);

    bounce = 1'b0;
    foreach (vecs[i]) begin
      start = vecs[i].start; up_req = vecs[i].up; down_req = vecs[i].down;
      speed_tgl = vecs[i].spd; pause_tgl = vecs[i].pse;
      cycle();
      idle_inputs();
      for (int k = 1; k < vecs[i].hold; k++) cycle();
      chk($sformatf("vec%0d_idx", i), note_idx, vecs[i].idx);
      chk($sformatf("vec%0d_dir", i), dir, vecs[i].dir);
      chk($sformatf("vec%0d_speed", i), speed, vecs[i].speed);
      chk($sformatf("vec%0d_audio", i), audio_en, vecs[i].audio);
      chk($sformatf("vec%0d_pulse", i), step_pulse, vecs[i].pulse);
    end

    do_start();
    cycle(); cycle();
    speed_tgl = 1'b1;
    cycle();
    idle_inputs();
    chk("spd_tgl_speed", speed, 0);
    cycles_to_step("spd_step_gap", 8);

    do_start();
    cycle();
    pause_tgl = 1'b1;
    cycle();
    idle_inputs();
    quiet_bad = 0;
    repeat (20) begin
      cycle();
      if (step_pulse || audio_en) quiet_bad++;
    end
    chk("paused_quiet", quiet_bad, 0);
    pause_tgl = 1'b1;
    cycle();
    idle_inputs();
    cycles_to_step("resume_gap", 3);

    bounce = 1'b0;
    do_start();
    repeat (29 * FAST) cycle();
    chk("end_idx", note_idx, TOP);
    chk("end_tone28", tone[TOP], 1);
    chk("end_audio", audio_en, 1);
    chk("end_pulse", step_pulse, 1);
    quiet_bad = 0;
    repeat (12) begin
      cycle();
      if (step_pulse) quiet_bad++;
    end
    chk("end_frozen_pulses", quiet_bad, 0);
    chk("end_frozen_idx", note_idx, TOP);
    down_req = 1'b1;
    cycle();
    idle_inputs();
    cycles_to_step("end_exit_gap", 4);
    chk("end_exit_idx", note_idx, TOP - 1);
    chk("end_exit_dir", dir, 0);

    bounce = 1'b1;
    do_start();
    repeat (27 * FAST) cycle();
    chk("bnc_idx27", note_idx, 27);
    for (int s = 0; s < 3; s++) begin
      cycles_to_step($sformatf("bnc_gap%0d", s), 4);
      idx_seen = (s == 1) ? 27 : (s == 0 ? 28 : 26);
      chk($sformatf("bnc_idx%0d", s), note_idx, idx_seen);
      if (s == 1) chk("bnc_dir_flip", dir, 0);
    end

    do_start();
    repeat (5 * FAST + 2) cycle();
    chk("pre_rst_idx", note_idx, 5);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_values("async_rst");
    cycle(); cycle();
    rst = 1'b1;
    repeat (4) cycle();
    chk("post_rst_idle_audio", audio_en, 0);
    start = 1'b1; up_req = 1'b1; down_req = 1'b1; pause_tgl = 1'b1;
    cycle();
    idle_inputs();
    chk("start_pri_idx", note_idx, 0);
    chk("start_pri_dir", dir, 1);
    chk("start_pri_audio", audio_en, 1);
    cycles_to_step("start_pri_step", 4);

    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) start = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) begin
        up_req = 1'($urandom_range(0, 1));
        down_req = 1'($urandom_range(0, 1));
      end
      speed_tgl = ($urandom_range(0, 39) == 0);
      pause_tgl = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) bounce = ~bounce;
      cycle();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
